ustc_sched: RTL and testbench
=============================

USTC_SCHED -- requirements
Module: ustc_sched

Interface
REQ-001 SHALL: parameter TILE_M, default 4, rows of the sparse tile.
REQ-002 SHALL: parameter TILE_N, default 4, columns of the output tile.
REQ-003 SHALL: parameter DW_CNT, default 8, width of the step count.
REQ-004 SHALL: parameter PIPE_LAT, default 4 (minimum 1), issue-to-result latency of the unstructured array datapath in cycles.
REQ-005 SHALL: clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL: reset, input, 1, synchronous active-high reset.
REQ-007 SHALL: start, input, 1, a one-cycle job request.
REQ-008 SHALL: num_steps, input, DW_CNT, number of compressed A/B step groups; sampled only when start is accepted.
REQ-009 SHALL: a_valid / a_ready, input / output, 1 each, handshake on the A nonzero/col/row/ctrl group stream.
REQ-010 SHALL: b_valid / b_ready, input / output, 1 each, handshake on the B vector stream.
REQ-011 SHALL: issue, output, 1, enables one array step in that cycle.
REQ-012 SHALL: acc_clear, output, 1, clears the fan-in accumulators together with the first issue of a job.
REQ-013 SHALL: step_idx, output, DW_CNT, index of the step being issued.
REQ-014 SHALL: out_valid / out_last, output, 1 each, array result valid, and marker for the final result of the job.
REQ-015 SHALL: busy / done, output, 1 each, job in progress, and one-cycle completion pulse.

Function
REQ-016 SHALL: the FSM has states IDLE, ISSUE, DRAIN and DONE; busy=1 in every state except IDLE.
REQ-017 SHALL: in IDLE, start=1 latches num_steps, clears step_idx and moves to ISSUE on the next cycle; if num_steps=0 it goes directly to DONE.
REQ-018 SHALL: start is ignored in every state except IDLE.
REQ-019 SHALL: issue = (state==ISSUE) & a_valid & b_valid, combinationally.
REQ-020 SHALL: a_ready = b_ready = issue; both streams transfer together and never individually.
REQ-021 SHALL: acc_clear = issue & (step_idx==0).
REQ-022 SHALL: each issue increments step_idx; the issue at step_idx==num_steps-1 moves the FSM to DRAIN.
REQ-023 SHALL: if either valid is low in ISSUE, the FSM stalls in ISSUE with no issue and step_idx held.
REQ-024 SHALL: out_valid equals issue delayed exactly PIPE_LAT cycles.
REQ-025 SHALL: out_last equals (issue of the final step) delayed PIPE_LAT cycles.
REQ-026 SHALL: DRAIN moves to DONE in the cycle after out_last=1.
REQ-027 SHALL: DONE asserts done=1 for one cycle and then returns to IDLE.
REQ-028 SHALL: num_steps=2^DW_CNT-1 completes with no counter wrap.
REQ-029 SHALL: step_idx does not advance past num_steps-1.

Reset
REQ-030 SHALL: reset forces IDLE and clears the step counter, latched count and latency pipeline.
REQ-031 SHALL: outputs are 0 during and after reset: busy, done, issue, acc_clear, out_valid, out_last, a_ready, b_ready and step_idx.
REQ-032 SHALL: reset in mid-job discards in-flight results, with no out_valid or done afterwards.

Configuration
REQ-033 SHALL: with USTC_SCHED_STALL_CNT_EN defined, an output stall_cnt [DW_CNT+8-1:0] counts the ISSUE-state cycles without issue; it clears on accepted start and on reset, and saturates at its maximum.
REQ-034 SHALL: without USTC_SCHED_STALL_CNT_EN, the stall_cnt port and its logic are absent and all other behaviour is identical.

Structure
REQ-035 SHALL: package ustc_pkg holds the FSM state typedef (IDLE/ISSUE/DRAIN/DONE) and the default PIPE_LAT and DW_CNT constants.
REQ-036 SHALL: the latency pipeline is sub-module ustc_lat_pipe, a PIPE_LAT-deep 2-bit shift register {valid, last} with synchronous reset.

Verification
REQ-037 SHALL: start with num_steps=3 and streams always valid -> issue on the 3 cycles after start; acc_clear only on the first; out_valid 3 cycles starting PIPE_LAT later; out_last on the third; done 1 cycle after out_last.
REQ-038 SHALL: num_steps=4 with b_valid low for 2 cycles after the second issue -> issue gap of 2 cycles; step_idx holds at 2; a_ready/b_ready low during the gap; out_valid shows the same gap.
REQ-039 SHALL: num_steps=0 -> DONE on the next cycle; done pulse; no issue, acc_clear or out_valid.
REQ-040 SHALL: start pulsed during ISSUE with num_steps=9 -> ignored; the job completes with its original count.
REQ-041 SHALL: reset asserted in DRAIN -> all outputs 0 the next cycle; no out_valid or done follows.
REQ-042 SHALL: with USTC_SCHED_STALL_CNT_EN defined, the REQ-038 scenario -> stall_cnt=2 at done.

Source files
------------

// File: rtl/ustc_pkg.sv
// ustc_pkg: shared types and defaults for the unstructured-sparse tile scheduler.
//   state_t      : scheduler FSM states (IDLE/ISSUE/DRAIN/DONE)
//   lat_t        : one latency-pipeline entry {valid, last}
//   PIPE_LAT_DEF : default issue-to-result latency of the array datapath
//   DW_CNT_DEF   : default width of the step count
package ustc_pkg;

    localparam int unsigned PIPE_LAT_DEF = 4;
    localparam int unsigned DW_CNT_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } lat_t;

endpackage

// File: rtl/ustc_lat_pipe.sv
// ustc_lat_pipe: DEPTH-deep shift register carrying {valid, last} so results
// appear exactly DEPTH cycles after their issue.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, empties the pipeline
//   din   : entry launched this cycle
//   dout  : entry launched DEPTH cycles ago
module ustc_lat_pipe
    import ustc_pkg::*;
#(
    parameter int unsigned DEPTH = PIPE_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  lat_t din,
    output lat_t dout
);

    lat_t pipe_q [DEPTH];

    // Shift chain; stage 0 captures the new entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ustc_sched.sv
// ustc_sched: issue scheduler for an unstructured-sparse tile array. Accepts a
// job of num_steps step groups, issues one array step per cycle in which both
// the A group stream and the B vector stream are valid, then waits for the
// last result to leave the datapath before pulsing done.
//   clk, reset            : clock, synchronous active-high reset
//   start, num_steps      : job request and its step count (sampled in IDLE)
//   a_valid/a_ready       : A nonzero/col/row/ctrl group handshake
//   b_valid/b_ready       : B vector handshake (transfers together with A)
//   issue, acc_clear      : array step enable, accumulator clear on first step
//   step_idx              : index of the step being issued
//   out_valid, out_last   : array result valid, final result of the job
//   busy, done            : job in progress, one-cycle completion pulse
//   stall_cnt             : ISSUE cycles without issue (only with
//                           USTC_SCHED_STALL_CNT_EN defined)
module ustc_sched
    import ustc_pkg::*;
#(
    parameter int unsigned TILE_M   = 4,
    parameter int unsigned TILE_N   = 4,
    parameter int unsigned DW_CNT   = DW_CNT_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DW_CNT-1:0] num_steps,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              b_valid,
    output logic              b_ready,
    output logic              issue,
    output logic              acc_clear,
    output logic [DW_CNT-1:0] step_idx,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef USTC_SCHED_STALL_CNT_EN
    ,
    output logic [DW_CNT+8-1:0] stall_cnt
`endif
);

    // Elaboration-time sanity check of the geometry and latency.
    if (TILE_M < 1 || TILE_N < 1 || PIPE_LAT < 1) begin : g_param_check
        $error("ustc_sched: TILE_M, TILE_N and PIPE_LAT must be at least 1");
    end

    state_t            state_q, state_d;
    logic [DW_CNT-1:0] count_q;
    logic [DW_CNT-1:0] idx_q;
    logic              issue_c;
    logic              last_issue_c;
    logic              start_ok_c;
    lat_t              pipe_in;
    lat_t              pipe_out;

    assign start_ok_c   = (state_q == IDLE) & start;
    assign issue_c      = (state_q == ISSUE) & a_valid & b_valid;
    // count_q is never 0 in ISSUE, so the subtraction cannot underflow there.
    assign last_issue_c = issue_c & (idx_q == count_q - DW_CNT'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_steps == '0) ? DONE : ISSUE;
            ISSUE:   if (last_issue_c) state_d = DRAIN;
            DRAIN:   if (pipe_out.last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched job length and step index; the index holds on the final step
    // so a full-range count never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            idx_q   <= '0;
        end else if (start_ok_c) begin
            count_q <= num_steps;
            idx_q   <= '0;
        end else if (issue_c && !last_issue_c) begin
            idx_q <= idx_q + DW_CNT'(1);
        end
    end

    assign pipe_in = '{valid: issue_c, last: last_issue_c};

    ustc_lat_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        issue     = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        acc_clear = 1'b0;
        step_idx  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            issue     = issue_c;
            a_ready   = issue_c;
            b_ready   = issue_c;
            acc_clear = issue_c & (idx_q == '0);
            step_idx  = idx_q;
            out_valid = pipe_out.valid;
            out_last  = pipe_out.last;
            busy      = (state_q != IDLE);
            done      = (state_q == DONE);
        end
    end

`ifdef USTC_SCHED_STALL_CNT_EN
    localparam int unsigned SCW = DW_CNT + 8;

    logic [SCW-1:0] stall_q;

    // Saturating count of ISSUE cycles lost to missing stream data.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (start_ok_c) begin
            stall_q <= '0;
        end else if ((state_q == ISSUE) && !issue_c && (stall_q != '1)) begin
            stall_q <= stall_q + SCW'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ustc_sched.sv
// tb_ustc_sched: directed and randomized stimulus for ustc_sched, checked every
// cycle against a job-level model (issued count, result schedule, done cycle).
module tb_ustc_sched;

    localparam int unsigned DW   = 8;
    localparam int unsigned LAT  = 4;
    localparam int          RING = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] num_steps;
    logic          a_valid;
    logic          b_valid;
    logic          a_ready;
    logic          b_ready;
    logic          issue;
    logic          acc_clear;
    logic [DW-1:0] step_idx;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef USTC_SCHED_STALL_CNT_EN
    logic [DW+7:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    ustc_sched #(
        .TILE_M   (4),
        .TILE_N   (4),
        .DW_CNT   (DW),
        .PIPE_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_steps (num_steps),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .issue     (issue),
        .acc_clear (acc_clear),
        .step_idx  (step_idx),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef USTC_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Job-level reference model.
    bit m_job      = 1'b0;
    int m_total    = 0;
    int m_issued   = 0;
    int m_begin    = 0;
    int m_done_cyc = -1;
    int m_stall    = 0;
    bit ring_v [RING];
    bit ring_l [RING];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clear_ring();
        for (int i = 0; i < RING; i++) begin
            ring_v[i] = 1'b0;
            ring_l[i] = 1'b0;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, then return 1 time unit later so the caller can drive new inputs.
    task automatic step();
        bit issuing;
        bit exp_issue;
        int slot;
        int nslot;
        @(negedge clk);
        slot      = cyc % RING;
        issuing   = m_job && (cyc >= m_begin) && (m_issued < m_total);
        exp_issue = !reset && issuing && a_valid && b_valid;
        chk("issue",     32'(issue),     32'(exp_issue));
        chk("a_ready",   32'(a_ready),   32'(exp_issue));
        chk("b_ready",   32'(b_ready),   32'(exp_issue));
        chk("acc_clear", 32'(acc_clear), 32'(exp_issue && (m_issued == 0)));
        chk("busy",      32'(busy),      32'(!reset && m_job && (cyc >= m_begin)));
        chk("done",      32'(done),      32'(!reset && m_job && (cyc == m_done_cyc)));
        chk("out_valid", 32'(out_valid), 32'(!reset && ring_v[slot]));
        chk("out_last",  32'(out_last),  32'(!reset && ring_l[slot]));
        if (reset) begin
            chk("step_idx_rst", 32'(step_idx), 32'd0);
        end else if (issuing) begin
            chk("step_idx", 32'(step_idx), 32'(m_issued));
        end
`ifdef USTC_SCHED_STALL_CNT_EN
        if (!reset) begin
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        end
`endif
        @(posedge clk);
        ring_v[slot] = 1'b0;
        ring_l[slot] = 1'b0;
        if (reset) begin
            m_job      = 1'b0;
            m_done_cyc = -1;
            m_stall    = 0;
            clear_ring();
        end else begin
            if (exp_issue) begin
                m_issued++;
                nslot = (cyc + int'(LAT)) % RING;
                ring_v[nslot] = 1'b1;
                if (m_issued == m_total) begin
                    ring_l[nslot] = 1'b1;
                    m_done_cyc    = cyc + int'(LAT) + 1;
                end
            end else if (issuing && m_stall < 65535) begin
                m_stall++;
            end
            if (m_job && cyc == m_done_cyc) begin
                m_job = 1'b0;
            end else if (!m_job && start) begin
                m_job      = 1'b1;
                m_total    = int'(num_steps);
                m_issued   = 0;
                m_begin    = cyc + 1;
                m_stall    = 0;
                m_done_cyc = (num_steps == '0) ? cyc + 1 : -1;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_steps = '0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        clear_ring();
        #1;
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // Three steps, streams always valid.
        start = 1'b1; num_steps = 8'd3; a_valid = 1'b1; b_valid = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();

        // Four steps with a two-cycle B gap after the second issue.
        start = 1'b1; num_steps = 8'd4;
        step();
        start = 1'b0;
        step();
        step();
        b_valid = 1'b0;
        step();
        step();
        b_valid = 1'b1;
        repeat (14) step();

        // Empty job.
        start = 1'b1; num_steps = 8'd0;
        step();
        start = 1'b0;
        repeat (4) step();

        // Start pulsed mid-job must be ignored.
        start = 1'b1; num_steps = 8'd5;
        step();
        start = 1'b0;
        step();
        start = 1'b1; num_steps = 8'd9;
        step();
        start = 1'b0;
        repeat (14) step();

        // Reset while draining.
        start = 1'b1; num_steps = 8'd2;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();

        // Full-range count.
        start = 1'b1; num_steps = 8'd255;
        step();
        start = 1'b0;
        repeat (265) step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom % 8) == 0;
            num_steps = DW'($urandom_range(0, 12));
            a_valid   = ($urandom % 4) != 0;
            b_valid   = ($urandom % 4) != 0;
            reset     = ($urandom % 200) == 0;
            step();
        end
        reset = 1'b0; start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
